// File: rtl/pc_unit.sv
// pc_unit: parametrised fetch-stage program counter with sequential increment,
// PC-relative branch, absolute jump and call/return backed by a circular
// return-address stack (RAS). The stack keeps the newest RAS_DEPTH return
// addresses; overflow and underflow raise a sticky error flag.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter int               INC       = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pcsignal,
  input  logic [2:0]                     pcsel,
  input  logic [WIDTH-1:0]               pcin,
  output logic [WIDTH-1:0]               pcout,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ras_err
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    SEL_INC    = 3'b000,
    SEL_HOLD   = 3'b001,
    SEL_BRANCH = 3'b010,
    SEL_JUMP   = 3'b011,
    SEL_CALL   = 3'b100,
    SEL_RET    = 3'b101,
    SEL_RSV6   = 3'b110,
    SEL_RSV7   = 3'b111
  } pcsel_e;

  pcsel_e           mode;
  logic [WIDTH-1:0] pc_q, pc_d, pc_seq, ras_top;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push;
  logic             full, empty;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign mode    = pcsel_e'(pcsel);
  assign pc_seq  = pc_q + WIDTH'(INC);
  assign ras_top = ras_mem[top_q];
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign empty   = (cnt_q == '0);

  // Next-state selection for PC, stack pointer, occupancy and error flag
  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (pcsignal) begin
      case (mode)
        SEL_INC:    pc_d = pc_seq;
        SEL_BRANCH: pc_d = pc_q + pcin;
        SEL_JUMP:   pc_d = pcin;
        SEL_CALL: begin
          // The top pointer advances even when full, so the push lands on
          // the oldest slot and the newest RAS_DEPTH entries survive.
          push  = 1'b1;
          top_d = top_q + PW'(1);
          pc_d  = pcin;
          if (full) err_d = 1'b1;
          else      cnt_d = cnt_q + CW'(1);
        end
        SEL_RET: begin
          if (empty) begin
            pc_d  = pc_seq;
            err_d = 1'b1;
          end else begin
            pc_d  = ras_top;
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ; // HOLD and reserved encodings keep all state
      endcase
    end
  end

  // PC and stack control registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Return-address storage; contents need no reset since occupancy gates use
  always_ff @(posedge clk) begin
    if (push && !reset) ras_mem[top_d] <= pc_seq;
  end

  assign pcout     = pc_q;
  assign ras_count = cnt_q;
  assign ras_full  = full;
  assign ras_empty = empty;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a queue-based reference model tracks the
// expected PC and return stack, a compare process checks every cycle, and
// directed sequences pin known values before a randomized phase.
module tb_pc_unit;

  localparam int          W     = 16;
  localparam int          INC   = 1;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RV    = 16'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcsignal = 1'b0;
  logic [2:0]  pcsel = 3'b000;
  logic [15:0] pcin = '0;
  logic [15:0] pcout;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ras_err;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  bit          m_err;

  pc_unit #(.WIDTH(W), .INC(INC), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pcsignal(pcsignal), .pcsel(pcsel), .pcin(pcin),
    .pcout(pcout), .ras_count(ras_count), .ras_full(ras_full),
    .ras_empty(ras_empty), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  // Reference model: stack newest at the back, oldest dropped on overflow
  initial begin
    m_pc = RV; m_err = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pc = RV; m_ras.delete(); m_err = 0;
      end else if (pcsignal) begin
        case (pcsel)
          3'd0: m_pc = m_pc + 16'(INC);
          3'd2: m_pc = m_pc + pcin;
          3'd3: m_pc = pcin;
          3'd4: begin
            m_ras.push_back(m_pc + 16'(INC));
            if (m_ras.size() > DEPTH) begin
              void'(m_ras.pop_front());
              m_err = 1;
            end
            m_pc = pcin;
          end
          3'd5: begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = m_pc + 16'(INC); m_err = 1; end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        logic [21:0] act, exp;
        act = {pcout, ras_count, ras_full, ras_empty, ras_err};
        exp = {m_pc, 3'(m_ras.size()), m_ras.size() == DEPTH, m_ras.size() == 0, m_err};
        check("cycle{pc,cnt,full,empty,err}", 32'(act), 32'(exp));
      end
    end
  end

  task automatic step(input bit s, input logic [2:0] sel, input logic [15:0] d);
    pcsignal = s; pcsel = sel; pcin = d;
    @(posedge clk); #1;
  endtask

  // Asserts reset between edges, checks the immediate effect, releases later
  task automatic async_reset();
    reset = 1'b1;
    #1;
    check("rst_pc", 32'(pcout), 32'(RV));
    check("rst_cnt", 32'(ras_count), 32'd0);
    check("rst_empty", 32'(ras_empty), 32'd1);
    check("rst_full", 32'(ras_full), 32'd0);
    check("rst_err", 32'(ras_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    started = 1'b1;

    // reset and sequential increment
    step(1, 3'd3, 16'h0555); check("jump0555", 32'(pcout), 32'h0555);
    #1; async_reset();
    step(1, 3'd0, 16'h0); check("inc1", 32'(pcout), 32'h0101);
    step(1, 3'd0, 16'h0); check("inc2", 32'(pcout), 32'h0102);
    step(1, 3'd0, 16'h0); check("inc3", 32'(pcout), 32'h0103);

    // stall, jump, reserved encodings
    step(0, 3'd3, 16'h1212); check("stall1", 32'(pcout), 32'h0103);
    step(0, 3'd3, 16'h1212); check("stall2", 32'(pcout), 32'h0103);
    step(1, 3'd3, 16'h1212); check("jump1212", 32'(pcout), 32'h1212);
    step(1, 3'd6, 16'h4444); check("sel6hold", 32'(pcout), 32'h1212);
    step(1, 3'd7, 16'h4444); check("sel7hold", 32'(pcout), 32'h1212);
    step(1, 3'd1, 16'h4444); check("hold", 32'(pcout), 32'h1212);

    // branch and wrap-around
    step(1, 3'd3, 16'h0010);
    step(1, 3'd2, 16'hFFF0); check("branch_neg", 32'(pcout), 32'h0000);
    step(1, 3'd3, 16'hFFFF);
    step(1, 3'd0, 16'h0);    check("inc_wrap", 32'(pcout), 32'h0000);
    step(1, 3'd3, 16'h7FF0);
    step(1, 3'd2, 16'h0020); check("branch_pos", 32'(pcout), 32'h8010);
    check("no_flag", 32'(ras_err), 32'd0);

    // nested call/return
    step(1, 3'd3, 16'h2000);
    step(1, 3'd4, 16'hAAAA); check("call1_pc", 32'(pcout), 32'hAAAA);
    check("call1_cnt", 32'(ras_count), 32'd1);
    step(1, 3'd4, 16'h2345); check("call2_cnt", 32'(ras_count), 32'd2);
    step(1, 3'd5, 16'h0);    check("ret1", 32'(pcout), 32'hAAAB);
    step(1, 3'd5, 16'h0);    check("ret2", 32'(pcout), 32'h2001);
    check("ret2_empty", 32'(ras_empty), 32'd1);
    check("ret2_err", 32'(ras_err), 32'd0);

    // overflow: return addresses are pcout+INC at each call
    step(1, 3'd3, 16'h0000);
    for (int i = 1; i <= 5; i++) step(1, 3'd4, 16'(i * 16));
    check("ovf_full", 32'(ras_full), 32'd1);
    check("ovf_err", 32'(ras_err), 32'd1);
    check("ovf_cnt", 32'(ras_count), 32'd4);
    step(1, 3'd5, 16'h0); check("ovf_ret1", 32'(pcout), 32'h0041);
    step(1, 3'd5, 16'h0); check("ovf_ret2", 32'(pcout), 32'h0031);
    step(1, 3'd5, 16'h0); check("ovf_ret3", 32'(pcout), 32'h0021);
    step(1, 3'd5, 16'h0); check("ovf_ret4", 32'(pcout), 32'h0011);
    check("ovf_empty", 32'(ras_empty), 32'd1);

    // underflow, stalled call, then reset clears the sticky flag
    async_reset();
    step(1, 3'd3, 16'hAFAF);
    step(1, 3'd5, 16'h0); check("unf_pc", 32'(pcout), 32'hAFB0);
    check("unf_err", 32'(ras_err), 32'd1);
    check("unf_cnt", 32'(ras_count), 32'd0);
    step(0, 3'd4, 16'h1234); check("stall_call_cnt", 32'(ras_count), 32'd0);
    check("stall_call_pc", 32'(pcout), 32'hAFB0);
    #1; async_reset();

    // randomized phase, weighted toward stack traffic
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] sel;
      bit s;
      if ($urandom_range(99) < 2) begin
        reset = 1'b1; #2; reset = 1'b0;
      end
      s = ($urandom_range(99) < 85);
      case ($urandom_range(9))
        0, 1, 2: sel = 3'd4;
        3, 4, 5: sel = 3'd5;
        default: sel = 3'($urandom_range(7));
      endcase
      step(s, sel, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
